// File: rtl/sys_ctrl_v2.sv
// Frame decoder and sequencer that links the UART RX byte stream to the register file, ALU and TX FIFO.
// Optional inter-byte timeout enabled by defining SYS_CTRL_TIMEOUT_EN.
module sys_ctrl_v2 #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned ALU_FUN_WIDTH  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [DATA_WIDTH-1:0]      RX_P_DATA,
  input  logic                       RX_D_VLD,
  input  logic [2*DATA_WIDTH-1:0]    ALU_OUT,
  input  logic                       OUT_Valid,
  input  logic [DATA_WIDTH-1:0]      RdData,
  input  logic                       RdData_Valid,
  input  logic                       FIFO_FULL,
  output logic [ALU_FUN_WIDTH-1:0]   ALU_FUN,
  output logic                       EN,
  output logic                       CLK_EN,
  output logic [ADDR_WIDTH-1:0]      Address,
  output logic                       WrEn,
  output logic                       RdEn,
  output logic [DATA_WIDTH-1:0]      WrData,
  output logic [DATA_WIDTH-1:0]      TX_P_DATA,
  output logic                       TX_D_VLD,
  output logic                       CMD_ERR
);

  localparam int unsigned RES_WIDTH = 2 * DATA_WIDTH;

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);
  localparam logic [DATA_WIDTH-1:0] CMD_BW     = DATA_WIDTH'(8'hEE);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN_S,
    ALU_WAIT, BW_ADDR, BW_CNT, BW_DATA, TX_LO, TX_HI
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  addr_r;
  logic [DATA_WIDTH-1:0]  cnt_r;
  logic [RES_WIDTH-1:0]   res;
  logic                   is_alu;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int unsigned TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_WIDTH-1:0] to_cnt;
  logic                rx_state;

  // States that expect another byte of the current frame
  assign rx_state = (state inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN_S,
                                   BW_ADDR, BW_CNT, BW_DATA});
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      addr_r    <= '0;
      cnt_r     <= '0;
      res       <= '0;
      is_alu    <= 1'b0;
      ALU_FUN   <= '0;
      EN        <= 1'b0;
      CLK_EN    <= 1'b0;
      Address   <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      CMD_ERR   <= 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      TX_D_VLD <= 1'b0;
      CMD_ERR  <= 1'b0;
      case (state)
        IDLE: if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_WR:     state <= WR_ADDR;
            CMD_RD:     state <= RD_ADDR;
            CMD_ALU_OP: state <= OP_A;
            CMD_ALU: begin
              state  <= ALU_FUN_S;
              CLK_EN <= 1'b1;
            end
            CMD_BW:     state <= BW_ADDR;
            default:    CMD_ERR <= 1'b1;
          endcase
        end
        WR_ADDR: if (RX_D_VLD) begin
          addr_r <= RX_P_DATA[ADDR_WIDTH-1:0];
          state  <= WR_DATA;
        end
        WR_DATA: if (RX_D_VLD) begin
          WrEn    <= 1'b1;
          Address <= addr_r;
          WrData  <= RX_P_DATA;
          state   <= IDLE;
        end
        RD_ADDR: if (RX_D_VLD) begin
          RdEn    <= 1'b1;
          Address <= RX_P_DATA[ADDR_WIDTH-1:0];
          state   <= RD_WAIT;
        end
        RD_WAIT: if (RdData_Valid) begin
          res    <= RES_WIDTH'(RdData);
          is_alu <= 1'b0;
          state  <= TX_LO;
        end
        OP_A: if (RX_D_VLD) begin
          WrEn    <= 1'b1;
          Address <= '0;
          WrData  <= RX_P_DATA;
          state   <= OP_B;
        end
        OP_B: if (RX_D_VLD) begin
          WrEn    <= 1'b1;
          Address <= ADDR_WIDTH'(1);
          WrData  <= RX_P_DATA;
          CLK_EN  <= 1'b1;
          state   <= ALU_FUN_S;
        end
        ALU_FUN_S: if (RX_D_VLD) begin
          ALU_FUN <= RX_P_DATA[ALU_FUN_WIDTH-1:0];
          EN      <= 1'b1;
          state   <= ALU_WAIT;
        end
        ALU_WAIT: if (OUT_Valid) begin
          res    <= ALU_OUT;
          is_alu <= 1'b1;
          EN     <= 1'b0;
          CLK_EN <= 1'b0;
          state  <= TX_LO;
        end
        BW_ADDR: if (RX_D_VLD) begin
          addr_r <= RX_P_DATA[ADDR_WIDTH-1:0];
          state  <= BW_CNT;
        end
        BW_CNT: if (RX_D_VLD) begin
          if (RX_P_DATA == '0) begin
            CMD_ERR <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt_r <= RX_P_DATA;
            state <= BW_DATA;
          end
        end
        BW_DATA: if (RX_D_VLD) begin
          WrEn    <= 1'b1;
          Address <= addr_r;
          WrData  <= RX_P_DATA;
          addr_r  <= addr_r + ADDR_WIDTH'(1);
          cnt_r   <= cnt_r - DATA_WIDTH'(1);
          if (cnt_r == DATA_WIDTH'(1)) state <= IDLE;
        end
        TX_LO: if (!FIFO_FULL) begin
          TX_D_VLD  <= 1'b1;
          TX_P_DATA <= res[DATA_WIDTH-1:0];
          state     <= is_alu ? TX_HI : IDLE;
        end
        // One idle cycle after the low word lets FIFO_FULL reflect that write
        TX_HI: if (!FIFO_FULL && !TX_D_VLD) begin
          TX_D_VLD  <= 1'b1;
          TX_P_DATA <= res[RES_WIDTH-1:DATA_WIDTH];
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef SYS_CTRL_TIMEOUT_EN
      if (rx_state && !RX_D_VLD) begin
        if (to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          to_cnt  <= '0;
          CMD_ERR <= 1'b1;
          CLK_EN  <= 1'b0;
          state   <= IDLE;
        end else begin
          to_cnt <= to_cnt + TO_WIDTH'(1);
        end
      end else begin
        to_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sys_ctrl_v2.sv
// Scoreboard bench for sys_ctrl_v2: frame-level reference model, RF/ALU responders, event monitor.
module tb_sys_ctrl_v2;
  localparam int TO = 16;
  localparam int EV_WR = 0, EV_RD = 1, EV_TX = 2, EV_ERR = 3, EV_ALU = 4;

  logic       CLK, RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic [15:0] ALU_OUT;
  logic       OUT_Valid;
  logic [7:0] RdData;
  logic       RdData_Valid;
  logic       FIFO_FULL;
  logic [3:0] ALU_FUN;
  logic       EN, CLK_EN;
  logic [3:0] Address;
  logic       WrEn, RdEn;
  logic [7:0] WrData, TX_P_DATA;
  logic       TX_D_VLD, CMD_ERR;

  sys_ctrl_v2 #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid), .RdData(RdData), .RdData_Valid(RdData_Valid),
    .FIFO_FULL(FIFO_FULL), .ALU_FUN(ALU_FUN), .EN(EN), .CLK_EN(CLK_EN), .Address(Address),
    .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .CMD_ERR(CMD_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct { int kind; int a; int d; } ev_t;
  ev_t exp_q[$];
  int  rd_q[$];
  int  alu_q[$];
  int  mem [16];
  int  n_chk = 0, n_fail = 0, n_tx = 0;
  logic full_q = 1'b0, en_q = 1'b0, fifo_rand = 1'b0;
  int  rd_v, alu_v;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  function automatic void push(input int kind, input int a, input int d);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d;
    exp_q.push_back(e);
  endfunction

  function automatic int alu_model(input int f, input int a, input int b);
    case (f & 15)
      0: return (a + b) & 16'hFFFF;
      1: return (a - b) & 16'hFFFF;
      2: return (a * b) & 16'hFFFF;
      3: return a & b;
      4: return a | b;
      default: return (a ^ b) | ((f & 15) << 8);
    endcase
  endfunction

  function automatic int rb();
    return int'($urandom_range(0, 255));
  endfunction

  task automatic observe(input int kind, input int a, input int d);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d a=%0h d=%0h, expected none", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.d != d) begin
        n_fail++;
        $display("FAIL event_order: got kind=%0d a=%0h d=%0h, expected kind=%0d a=%0h d=%0h",
                 kind, a, d, e.kind, e.a, e.d);
      end
    end
  endtask

  always @(posedge CLK) full_q <= FIFO_FULL;

  // Monitor: every DUT-side event is compared with the next expected one
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (WrEn || RdEn || TX_D_VLD)
        chk("strobe_exclusive", longint'($countones({WrEn, RdEn, TX_D_VLD}) > 1), 0);
      if (WrEn) observe(EV_WR, int'(Address), int'(WrData));
      if (RdEn) observe(EV_RD, int'(Address), 0);
      if (TX_D_VLD) begin
        n_tx++;
        chk("tx_while_full", longint'(full_q), 0);
        observe(EV_TX, 0, int'(TX_P_DATA));
      end
      if (CMD_ERR) observe(EV_ERR, 0, 0);
      if (EN && !en_q) observe(EV_ALU, 0, int'(ALU_FUN));
      en_q <= EN;
    end else begin
      en_q <= 1'b0;
    end
  end

  // Register-file read responder
  always begin
    @(negedge CLK);
    if (RST === 1'b1 && RdEn === 1'b1) begin
      rd_v = 0;
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else rd_v = rd_q.pop_front();
      repeat ($urandom_range(1, 3)) @(posedge CLK);
      #1 RdData = 8'(rd_v); RdData_Valid = 1'b1;
      @(posedge CLK);
      #1 RdData_Valid = 1'b0;
    end
  end

  // ALU responder, also checks EN/CLK_EN around OUT_Valid
  always begin
    @(negedge CLK);
    if (RST === 1'b1 && EN === 1'b1) begin
      alu_v = 0;
      if (alu_q.size() == 0) chk("alu_unexpected", 1, 0);
      else alu_v = alu_q.pop_front();
      repeat ($urandom_range(1, 4)) @(posedge CLK);
      #1 ALU_OUT = 16'(alu_v); OUT_Valid = 1'b1;
      @(negedge CLK);
      chk("en_clk_en_during_out_valid", longint'({EN, CLK_EN}), 3);
      @(posedge CLK);
      #1 OUT_Valid = 1'b0;
      @(negedge CLK);
      chk("en_clk_en_after_out_valid", longint'({EN, CLK_EN}), 0);
    end
  end

  always @(posedge CLK) if (fifo_rand) #1 FIFO_FULL = ($urandom_range(0, 3) == 0);

  task automatic send_byte(input int b);
    @(posedge CLK);
    #1 RX_P_DATA = 8'(b); RX_D_VLD = 1'b1;
    @(posedge CLK);
    #1 RX_D_VLD = 1'b0; RX_P_DATA = 8'(rb());
    repeat ($urandom_range(0, 3)) @(posedge CLK);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      @(posedge CLK);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      chk("wait_idle_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(posedge CLK);
  endtask

  task automatic do_wr(input int a, input int d);
    push(EV_WR, a & 15, d); mem[a & 15] = d;
    send_byte(8'hAA); send_byte(a); send_byte(d);
    wait_idle();
  endtask

  task automatic do_rd(input int a);
    push(EV_RD, a & 15, 0); push(EV_TX, 0, mem[a & 15]); rd_q.push_back(mem[a & 15]);
    send_byte(8'hBB); send_byte(a);
    wait_idle();
  endtask

  task automatic push_alu(input int f);
    int r = alu_model(f, mem[0], mem[1]);
    push(EV_ALU, 0, f & 15); alu_q.push_back(r);
    push(EV_TX, 0, r & 8'hFF); push(EV_TX, 0, (r >> 8) & 8'hFF);
  endtask

  task automatic do_alu_ops(input int a, input int b, input int f, input bit stall);
    int t0, cyc;
    push(EV_WR, 0, a); push(EV_WR, 1, b); mem[0] = a; mem[1] = b;
    push_alu(f);
    send_byte(8'hCC); send_byte(a); send_byte(b);
    if (stall) begin
      @(posedge CLK); #1 RX_P_DATA = 8'(f); RX_D_VLD = 1'b1;
      @(posedge CLK); #1 RX_D_VLD = 1'b0; FIFO_FULL = 1'b1;
      t0 = n_tx; cyc = 0;
      while (OUT_Valid !== 1'b1 && cyc < 50) begin @(negedge CLK); cyc++; end
      chk("stall_out_valid_seen", longint'(OUT_Valid), 1);
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      chk("no_tx_while_stalled", n_tx - t0, 0);
      @(posedge CLK); #1 FIFO_FULL = 1'b0;
    end else begin
      send_byte(f);
    end
    wait_idle();
  endtask

  task automatic do_alu(input int f);
    push_alu(f);
    send_byte(8'hDD); send_byte(f);
    wait_idle();
  endtask

  task automatic do_burst(input int a, input int n);
    int d;
    send_byte(8'hEE); send_byte(a);
    if (n == 0) push(EV_ERR, 0, 0);
    send_byte(n);
    for (int i = 0; i < n; i++) begin
      d = rb();
      push(EV_WR, (a + i) & 15, d); mem[(a + i) & 15] = d;
      send_byte(d);
    end
    wait_idle();
  endtask

  task automatic do_bad(input int b);
    push(EV_ERR, 0, 0);
    send_byte(b);
    wait_idle();
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk(nm, longint'({ALU_FUN, EN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_DATA,
                      TX_D_VLD, CMD_ERR}), 0);
  endtask

  initial begin
    int b, cyc, fa;
    RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; ALU_OUT = '0; OUT_Valid = 1'b0;
    RdData = '0; RdData_Valid = 1'b0; FIFO_FULL = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 0;
    repeat (3) @(negedge CLK);
    chk_outputs_zero("reset_outputs");
    @(posedge CLK); #1 RST = 1'b1;
    repeat (2) @(posedge CLK);

    do_wr(8'h05, 8'h3C);
    do_rd(8'h05);
    do_alu_ops(8'h10, 8'h20, 8'h00, 1'b0);
    chk("alu_add_result_model", alu_model(0, 8'h10, 8'h20), 16'h0030);
    do_burst(8'h0E, 3);
    do_burst(8'h02, 0);
    do_alu_ops(8'h9A, 8'h37, 8'h02, 1'b1);
    do_bad(8'h7F);

    // Reset while waiting for operand B
    fa = rb();
    push(EV_WR, 0, fa); mem[0] = fa;
    send_byte(8'hCC); send_byte(fa);
    wait_idle();
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    chk_outputs_zero("reset_mid_frame_outputs");
    repeat (2) @(posedge CLK); #1 RST = 1'b1;
    do_alu(8'h01);

`ifdef SYS_CTRL_TIMEOUT_EN
    // 16 edges in WR_ADDR without a byte; the error pulse is seen at the negedge after the 16th
    push(EV_ERR, 0, 0);
    @(posedge CLK); #1 RX_P_DATA = 8'hAA; RX_D_VLD = 1'b1;
    @(posedge CLK); #1 RX_D_VLD = 1'b0;
    cyc = 0;
    while (CMD_ERR !== 1'b1 && cyc < 3 * TO) begin @(negedge CLK); cyc++; end
    chk("timeout_latency", cyc, TO + 1);
    wait_idle();
`else
    send_byte(8'hAA);
    repeat (3 * TO) @(posedge CLK);
    chk("no_timeout_pending", exp_q.size(), 0);
    push(EV_WR, 3, 8'h5A); mem[3] = 8'h5A;
    send_byte(8'h03); send_byte(8'h5A);
    wait_idle();
`endif

    fifo_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: do_wr(rb(), rb());
        1: do_rd(rb());
        2: do_alu_ops(rb(), rb(), rb(), 1'b0);
        3: do_alu(rb());
        4: do_burst(rb(), int'($urandom_range(0, 5)));
        default: begin
          b = rb();
          while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD || b == 8'hEE) b = rb();
          do_bad(b);
        end
      endcase
    end
    fifo_rand = 1'b0;
    @(posedge CLK); #2 FIFO_FULL = 1'b0;
    repeat (4) @(posedge CLK);
    chk("final_queue_empty", exp_q.size() + rd_q.size() + alu_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end
endmodule
